// File: rtl/prll_bs_pkg.sv
// Shared constants and header layout for the parallel bus port.
// Field positions are derived from the bus word width.
package prll_bs_pkg;

  localparam logic [7:0] BROADCAST_DEF = 8'hFF;

  function automatic int trgt_msb(input int bits);
    return bits - 1;
  endfunction

  function automatic int trgt_lsb(input int bits);
    return bits - 8;
  endfunction

  function automatic int src_msb(input int bits);
    return bits - 9;
  endfunction

  function automatic int src_lsb(input int bits);
    return bits - 16;
  endfunction

  function automatic int msgid_msb(input int bits);
    return bits - 17;
  endfunction

  function automatic int msgid_lsb(input int bits);
    return bits - 32;
  endfunction

  typedef struct packed {
    logic [7:0]  trgt;
    logic [7:0]  src;
    logic [15:0] msg_id;
  } bs_hdr_t;

endpackage

// File: rtl/prll_bs_drvr_port_if.sv
// Host, arbiter and bus signals of one driver port.
// The port itself uses the slave view.
interface prll_bs_drvr_port_if #(
  parameter int BITS  = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            tx_vld;
  logic            tx_rdy;
  logic [7:0]      tx_trgt;
  logic [BITS-17:0] tx_pld;
  logic            pndng;
  logic [BITS-1:0] D_pop;
  logic            pop;
  logic            push;
  logic [BITS-1:0] D_push;
  logic            rx_vld;
  logic            rx_rdy;
  logic [BITS-1:0] rx_data;
  logic [CW-1:0]   tx_cnt;
  logic [CW-1:0]   rx_cnt;
  logic [15:0]     drop_cnt;
  logic [1:0]      err;

  modport slave (
    input  tx_vld, tx_trgt, tx_pld,
    input  pop, push, D_push, rx_rdy,
    output tx_rdy, pndng, D_pop,
    output rx_vld, rx_data,
    output tx_cnt, rx_cnt, drop_cnt, err
  );

  modport master (
    output tx_vld, tx_trgt, tx_pld,
    output pop, push, D_push, rx_rdy,
    input  tx_rdy, pndng, D_pop,
    input  rx_vld, rx_data,
    input  tx_cnt, rx_cnt, drop_cnt, err
  );

endinterface

// File: rtl/prll_bs_drvr_port_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// Head reads as zero while empty.
module bs_fifo_fwft #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign do_rd = rd_en && !empty;
  // a full FIFO still takes a write when the head leaves on the same edge
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q + AW'(do_wr);
    rptr_d = rptr_q + AW'(do_rd);
    cnt_d  = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/prll_bs_drvr_port.sv
// Device-side parallel bus port: TX buffer toward the arbiter,
// RX address filter and buffer toward the host.
module prll_bs_drvr_port
  import prll_bs_pkg::*;
#(
  parameter int         BITS      = 32,
  parameter int         DEPTH     = 16,
  parameter int         ID        = 0,
  parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
  input logic clk,
  input logic reset,
  prll_bs_drvr_port_if.slave bus
);
  localparam logic [7:0] MY_ID = 8'(ID);
  localparam int TM = trgt_msb(BITS);
  localparam int TL = trgt_lsb(BITS);
  localparam int SM = src_msb(BITS);
  localparam int SL = src_lsb(BITS);

  logic            tx_full, tx_empty, tx_wr;
  logic            rx_full, rx_empty, rx_wr, rx_rd;
  logic [BITS-1:0] tx_word;
  logic [7:0]      t, s;
  logic            hit, rx_room;
  logic [15:0]     drop_q, drop_d;
  logic [1:0]      err_q, err_d;

  assign tx_word = {bus.tx_trgt, MY_ID, bus.tx_pld};
  assign tx_wr   = bus.tx_vld && !tx_full;

  assign t = bus.D_push[TM:TL];
  assign s = bus.D_push[SM:SL];
  // own broadcasts echoed back by the bus are not delivered
  assign hit = (t == MY_ID || t == BROADCAST)
            && !(t == BROADCAST && s == MY_ID);
  assign rx_rd   = bus.rx_rdy && !rx_empty;
  assign rx_room = !rx_full || rx_rd;
  assign rx_wr   = bus.push && hit && rx_room;

  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (bus.push && !(hit && rx_room) && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
    if (bus.pop && tx_empty)
      err_d[0] = 1'b1;
    if (bus.push && hit && !rx_room)
      err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  bs_fifo_fwft #(.W(BITS), .DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (tx_wr),
    .wr_data (tx_word),
    .rd_en   (bus.pop),
    .rd_data (bus.D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (bus.tx_cnt)
  );

  bs_fifo_fwft #(.W(BITS), .DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (rx_wr),
    .wr_data (bus.D_push),
    .rd_en   (bus.rx_rdy),
    .rd_data (bus.rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (bus.rx_cnt)
  );

  assign bus.tx_rdy   = !tx_full;
  assign bus.pndng    = !tx_empty;
  assign bus.rx_vld   = !rx_empty;
  assign bus.drop_cnt = drop_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_prll_bs_drvr_port.sv
// Self-checking bench for prll_bs_drvr_port (ID=1, 32-bit, depth 16).
// Queue models of both FIFOs plus a filter table and corner sequences.
module tb_prll_bs_drvr_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prll_bs_drvr_port_if #(.BITS(32), .DEPTH(16)) bus ();

  prll_bs_drvr_port #(
    .BITS(32), .DEPTH(16), .ID(1), .BROADCAST(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [15:0] drop_m;
  logic [1:0]  err_m;

  typedef struct {
    logic [31:0] d;
    bit          acc;
    logic [15:0] drop_exp;
  } rxv_t;
  rxv_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit exp_hit(input logic [31:0] d);
    logic [7:0] tg, sr;
    tg = d[31:24];
    sr = d[23:16];
    return (tg == 8'h01 || tg == 8'hFF) && !(tg == 8'hFF && sr == 8'h01);
  endfunction

  task automatic idle();
    bus.tx_vld = 0; bus.tx_trgt = '0; bus.tx_pld = '0;
    bus.pop = 0; bus.push = 0; bus.D_push = '0; bus.rx_rdy = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pndng"}, 32'(bus.pndng), 32'(txq.size() > 0));
    chk({tag, "_tx_rdy"}, 32'(bus.tx_rdy), 32'(txq.size() < 16));
    chk({tag, "_tx_cnt"}, 32'(bus.tx_cnt), 32'(txq.size()));
    chk({tag, "_rx_vld"}, 32'(bus.rx_vld), 32'(rxq.size() > 0));
    chk({tag, "_rx_cnt"}, 32'(bus.rx_cnt), 32'(rxq.size()));
    chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'(drop_m));
    chk({tag, "_err"}, 32'(bus.err), 32'(err_m));
    chk({tag, "_dpop"}, bus.D_pop, txq.size() > 0 ? txq[0] : 32'h0);
    chk({tag, "_rxdata"}, bus.rx_data, rxq.size() > 0 ? rxq[0] : 32'h0);
  endtask

  // One clock of stimulus; model decides what the DUT must do.
  task automatic cyc(input bit tv, input logic [7:0] tt,
                     input logic [15:0] tp, input bit pp, input bit ps,
                     input logic [31:0] dp, input bit rr, input bit acc,
                     input string tag);
    bit wr, rrd, room;
    wr   = tv && (txq.size() < 16);
    rrd  = rr && (rxq.size() > 0);
    room = (rxq.size() < 16) || rrd;
    if (pp && txq.size() == 0) err_m[0] = 1'b1;
    if (pp && txq.size() > 0) chk({tag, "_popword"}, bus.D_pop, txq.pop_front());
    if (rrd) chk({tag, "_rxword"}, bus.rx_data, rxq.pop_front());
    bus.tx_vld = tv; bus.tx_trgt = tt; bus.tx_pld = tp;
    bus.pop = pp; bus.push = ps; bus.D_push = dp; bus.rx_rdy = rr;
    @(posedge clk);
    #1;
    idle();
    if (wr) txq.push_back({tt, 8'h01, tp});
    if (ps) begin
      if (acc && room) rxq.push_back(dp);
      else begin
        if (drop_m != 16'hFFFF) drop_m++;
        if (acc) err_m[1] = 1'b1;
      end
    end
    check_all(tag);
  endtask

  task automatic clear_model();
    txq.delete();
    rxq.delete();
    drop_m = '0;
    err_m  = '0;
  endtask

  initial begin
    tbl[0] = '{32'h0103_0007, 1'b1, 16'd0};
    tbl[1] = '{32'h0203_0007, 1'b0, 16'd1};
    tbl[2] = '{32'hFF03_0001, 1'b1, 16'd1};
    tbl[3] = '{32'hFF01_0001, 1'b0, 16'd2};
    tbl[4] = '{32'h0101_0002, 1'b1, 16'd2};
    tbl[5] = '{32'h0001_0003, 1'b0, 16'd3};
    tbl[6] = '{32'hFF02_00AA, 1'b1, 16'd3};
    tbl[7] = '{32'h01FF_1234, 1'b1, 16'd3};

    idle();
    clear_model();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    reset = 1'b0;

    // single message through TX
    cyc(1, 8'h02, 16'h0005, 0, 0, '0, 0, 0, "t1_wr");
    chk("t1_pndng", 32'(bus.pndng), 32'd1);
    chk("t1_dpop", bus.D_pop, 32'h0201_0005);
    cyc(0, '0, '0, 1, 0, '0, 0, 0, "t1_pop");
    chk("t1_cnt", 32'(bus.tx_cnt), 32'd0);

    // fill TX, overflow attempt, pop at full
    for (int i = 0; i < 16; i++)
      cyc(1, 8'(i + 16), 16'(i * 3), 0, 0, '0, 0, 0, "t2_fill");
    chk("t2_rdy_full", 32'(bus.tx_rdy), 32'd0);
    chk("t2_cnt_full", 32'(bus.tx_cnt), 32'd16);
    cyc(1, 8'hEE, 16'hDEAD, 0, 0, '0, 0, 0, "t2_17th");
    cyc(1, 8'hEE, 16'hBEEF, 1, 0, '0, 0, 0, "t2_popfull");
    chk("t2_rdy_after", 32'(bus.tx_rdy), 32'd1);
    cyc(1, 8'h33, 16'h1234, 1, 0, '0, 0, 0, "t2_wrpop");
    chk("t2_cnt_wrpop", 32'(bus.tx_cnt), 32'd15);
    for (int i = 0; i < 15; i++)
      cyc(0, '0, '0, 1, 0, '0, 0, 0, "t2_drain");

    // RX address filter table
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, '0, 0, 1, tbl[i].d, 0, tbl[i].acc, "t3_tbl");
      chk("t3_tbl_drop", 32'(bus.drop_cnt), 32'(tbl[i].drop_exp));
    end
    chk("t3_err", 32'(bus.err), 32'd0);
    for (int i = 0; i < 5; i++)
      cyc(0, '0, '0, 0, 0, '0, 1, 0, "t3_drain");

    // RX overflow, then push with simultaneous read at full
    for (int i = 0; i < 16; i++)
      cyc(0, '0, '0, 0, 1, {16'h0103, 16'(i)}, 0, 1, "t5_fill");
    cyc(0, '0, '0, 0, 1, 32'h0103_00AA, 0, 1, "t5_ovf");
    chk("t5_err1", 32'(bus.err), 32'd2);
    cyc(0, '0, '0, 0, 1, 32'h0103_00BB, 1, 1, "t5_rdwr");
    chk("t5_cnt16", 32'(bus.rx_cnt), 32'd16);

    // pop while empty, then async reset mid-stream
    cyc(0, '0, '0, 1, 0, '0, 0, 0, "t6_popempty");
    chk("t6_err", 32'(bus.err), 32'd3);
    for (int i = 0; i < 3; i++)
      cyc(1, 8'h05, 16'(i), 0, 0, '0, 0, 0, "t6_txfill");
    reset = 1'b1;
    #2;
    chk("t6_ar_pndng", 32'(bus.pndng), 32'd0);
    chk("t6_ar_rxvld", 32'(bus.rx_vld), 32'd0);
    chk("t6_ar_txrdy", 32'(bus.tx_rdy), 32'd1);
    chk("t6_ar_txcnt", 32'(bus.tx_cnt), 32'd0);
    chk("t6_ar_rxcnt", 32'(bus.rx_cnt), 32'd0);
    chk("t6_ar_drop", 32'(bus.drop_cnt), 32'd0);
    chk("t6_ar_err", 32'(bus.err), 32'd0);
    chk("t6_ar_dpop", bus.D_pop, 32'd0);
    chk("t6_ar_rxdata", bus.rx_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    check_all("t6_post");

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  tg, sr;
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: tg = 8'h01;
        1: tg = 8'h02;
        2: tg = 8'hFF;
        default: tg = 8'h00;
      endcase
      sr = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h03;
      d  = {tg, sr, 16'($urandom)};
      cyc($urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, d,
          $urandom_range(0, 3) == 0, exp_hit(d), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
